nvme_perr_capture: RTL
======================

Name: nvme_perr_capture

Overview:
- Downstream collector for the per-interface parity checkers in the NVMe AFU.
- Takes the single-bit, combinational parerr outputs of up to num_sources checkers and registers them.
- Latches sticky per-source status, records the first-failing source, and counts error cycles.
- Drives an interrupt request/acknowledge handshake toward the AFU error/MMIO logic.

Parameters:
- num_sources, 8, number of parity-check sources; 1..32.
- src_width, 5, width of the source index; must satisfy 2^src_width >= num_sources.
- cnt_width, 16, width of the saturating error-cycle counter.

Ports:
- clk  input  1  core clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- perr_in  input  num_sources  raw parerr from checkers; bit i = source i; may be any value every cycle.
- mask  input  num_sources  1 = source excluded from interrupt (still sticky/counted).
- clr_valid  input  1  one-cycle clear strobe from MMIO.
- clr_bits  input  num_sources  write-1-to-clear bits for sticky status, applied when clr_valid=1.
- clr_cnt  input  1  with clr_valid: zero the counter and re-arm first-error capture.
- int_ack  input  1  interrupt acknowledge; honoured only in REPORT.
- perr_sticky  output  num_sources  sticky per-source error status.
- first_valid  output  1  first_src holds a captured value.
- first_src  output  src_width  index of the first source to fail since the last re-arm.
- err_cnt  output  cnt_width  saturating count of cycles with any registered error.
- int_req  output  1  interrupt request level.

Behaviour:
- Reset (reset_n=0, async): perr_q, perr_sticky, first_valid, first_src, err_cnt and int_req are 0; FSM in IDLE.
- Stage 1: perr_q <= perr_in on every edge. This is a timing flop only; there is no filtering.
- Stage 2, sticky update: perr_sticky <= (perr_sticky & ~(clr_valid ? clr_bits : 0)) | perr_q.
  - A new error on the same bit in the same cycle as its clear wins: the bit stays set.
- First error capture:
  - When first_valid=0 and perr_q != 0: first_src <= lowest set index of perr_q; first_valid <= 1.
  - If several bits are set in the same cycle, the lowest index wins.
  - clr_valid & clr_cnt sets first_valid <= 0. A simultaneous perr_q != 0 recaptures in that same cycle, so first_valid stays 1 with the new index.
- Counter:
  - err_cnt increments by 1 per cycle with perr_q != 0, independent of how many bits are set.
  - Saturates at all-ones with no wrap.
  - clr_valid & clr_cnt zeroes it; a simultaneous error leaves err_cnt = 1.
- Latency: an error on perr_in at edge N appears on perr_sticky, first_src, err_cnt and int_req after edge N+2.
- Interrupt FSM (pend = |(perr_sticky_next & ~mask)):
  - IDLE: int_req=0. Go to REPORT when pend=1.
  - REPORT: int_req=1. On int_ack go to HOLD (int_req drops the next cycle). int_ack outside REPORT is ignored.
  - HOLD: int_req=0. Go to IDLE when pend=0, i.e. software cleared or masked every unmasked sticky bit. A new error on an already-sticky bit does not re-interrupt.
  - HOLD with a newly set, unmasked bit (0 to 1 transition this cycle): go to REPORT.
- Mask changes:
  - Take effect combinationally on pend.
  - Unmasking a sticky bit in IDLE raises int_req on the next edge.
  - Masking all pending bits in REPORT does not withdraw int_req; it is held until int_ack.
- Reset mid-handshake returns the FSM to IDLE immediately; int_req drops asynchronously.

Optional Feature:
- Macro NVME_PERR_INJECT_EN.
- Defined:
  - Adds ports inj_valid (in, 1) and inj_bits (in, num_sources).
  - perr_q <= perr_in | (inj_valid ? inj_bits : 0).
  - Injected errors behave identically to real ones.
- Undefined: the ports are absent and perr_q <= perr_in.

Decomposition:
- Shared package (nvme_perr_pkg):
  - FSM state typedef {IDLE, REPORT, HOLD}, 2-bit encoding 00/01/10.
  - Default-width localparams.
  - Lowest-set-bit priority-encode function, reused by the other error collectors.
- One natural sub-module: nvme_perr_prienc, a parameterised priority encoder returning index and any-set.
- Everything else stays inline.

Test Plan:
- Reset, then perr_in=8'h00 for 10 cycles: all outputs 0, int_req never asserts.
- perr_in=8'h28 for one cycle, mask=0: 2 edges later perr_sticky=8'h28, first_src=3, first_valid=1, err_cnt=1, int_req=1. int_ack for one cycle: int_req=0 next cycle, FSM in HOLD.
- In HOLD, clr_valid with clr_bits=8'h08 and perr_in bit 3 pulsing at the same point: sticky stays 8'h28. clr_bits=8'h28 with no error: sticky=0, FSM returns to IDLE.
- mask=8'h01, perr_in=8'h01: sticky=8'h01 and err_cnt increments, but int_req stays 0. Then mask=0: int_req=1 the next cycle.
- cnt_width=4, perr_in=1 held for 20 cycles: err_cnt reaches 4'hF and holds. clr_valid&clr_cnt with the error still present: err_cnt=1, first_valid=1.
- With NVME_PERR_INJECT_EN defined: inj_valid=1, inj_bits=8'h80 gives first_src=7 and int_req=1. Assert reset_n=0 while in REPORT: int_req drops immediately with no clock.

Source files
------------

// File: rtl/nvme_perr_pkg.sv
// nvme_perr_pkg
//   Shared definitions for the NVMe AFU parity-error collectors.
//   - perr_state_e : interrupt handshake states (IDLE/REPORT/HOLD)
//   - DEFAULT_*    : default widths used by nvme_perr_capture
//   - lowest_set_idx : lowest-set-bit priority encode over up to 32 sources
package nvme_perr_pkg;

    localparam int DEFAULT_NUM_SOURCES = 8;
    localparam int DEFAULT_SRC_WIDTH   = 5;
    localparam int DEFAULT_CNT_WIDTH   = 16;
    localparam int MAX_SOURCES         = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REPORT = 2'b01,
        HOLD   = 2'b10
    } perr_state_e;

    // Index of the lowest set bit; returns 0 when no bit is set, so callers
    // must qualify the result with their own any-set flag.
    function automatic logic [4:0] lowest_set_idx(input logic [MAX_SOURCES-1:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = MAX_SOURCES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/nvme_perr_prienc.sv
// nvme_perr_prienc
//   Parameterised lowest-index priority encoder.
//   Ports:
//     req     in  [width]      request vector
//     idx     out [idx_width]  index of lowest set bit (0 when none set)
//     any_set out 1            at least one bit of req is set
module nvme_perr_prienc
    import nvme_perr_pkg::*;
#(
    parameter int width     = DEFAULT_NUM_SOURCES,
    parameter int idx_width = DEFAULT_SRC_WIDTH
) (
    input  logic [width-1:0]     req,
    output logic [idx_width-1:0] idx,
    output logic                 any_set
);

    logic [MAX_SOURCES-1:0] req_ext;
    logic [4:0]             idx_full;

    // Widen to the shared function's fixed width, then resize the index.
    always_comb begin
        req_ext              = '0;
        req_ext[width-1:0]   = req;
        idx_full             = lowest_set_idx(req_ext);
        idx                  = idx_width'(idx_full);
        any_set              = |req;
    end

endmodule

// File: rtl/nvme_perr_capture.sv
// nvme_perr_capture
//   Collects the combinational parerr outputs of up to num_sources parity
//   checkers: registers them, keeps sticky per-source status, records the
//   first failing source, counts error cycles (saturating) and runs an
//   interrupt request/acknowledge handshake.
//   Optional macro NVME_PERR_INJECT_EN adds inj_valid/inj_bits error injection.
//   Ports:
//     clk, reset_n          clock, asynchronous active-low reset
//     perr_in   [N]         raw parity errors, bit i = source i
//     mask      [N]         1 = source excluded from interrupt
//     clr_valid/clr_bits    write-1-to-clear sticky bits
//     clr_cnt               with clr_valid: zero counter, re-arm first capture
//     int_ack               interrupt acknowledge (only honoured in REPORT)
//     inj_valid/inj_bits    error injection (NVME_PERR_INJECT_EN only)
//     perr_sticky [N]       sticky status
//     first_valid/first_src first failing source since last re-arm
//     err_cnt               saturating count of cycles with any error
//     int_req               interrupt request level
module nvme_perr_capture
    import nvme_perr_pkg::*;
#(
    parameter int num_sources = DEFAULT_NUM_SOURCES,
    parameter int src_width   = DEFAULT_SRC_WIDTH,
    parameter int cnt_width   = DEFAULT_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [num_sources-1:0] perr_in,
    input  logic [num_sources-1:0] mask,
    input  logic                   clr_valid,
    input  logic [num_sources-1:0] clr_bits,
    input  logic                   clr_cnt,
    input  logic                   int_ack,
`ifdef NVME_PERR_INJECT_EN
    input  logic                   inj_valid,
    input  logic [num_sources-1:0] inj_bits,
`endif
    output logic [num_sources-1:0] perr_sticky,
    output logic                   first_valid,
    output logic [src_width-1:0]   first_src,
    output logic [cnt_width-1:0]   err_cnt,
    output logic                   int_req
);

    logic [num_sources-1:0] perr_raw;
    logic [num_sources-1:0] perr_q;
    logic [num_sources-1:0] clr_eff;
    logic [num_sources-1:0] sticky_next;
    logic [num_sources-1:0] fresh_unmasked;
    logic                   pend;
    logic                   rearm;
    logic [src_width-1:0]   enc_idx;
    logic                   enc_any;
    perr_state_e            state;
    perr_state_e            state_next;

`ifdef NVME_PERR_INJECT_EN
    assign perr_raw = perr_in | (inj_valid ? inj_bits : '0);
`else
    assign perr_raw = perr_in;
`endif

    // Timing flop between the checkers and the collector; no filtering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perr_q <= '0;
        end else begin
            perr_q <= perr_raw;
        end
    end

    // Sticky next value: a clear never beats an error on the same bit in the
    // same cycle. fresh_unmasked marks unmasked 0->1 sticky transitions.
    always_comb begin
        clr_eff        = clr_valid ? clr_bits : '0;
        sticky_next    = (perr_sticky & ~clr_eff) | perr_q;
        fresh_unmasked = sticky_next & ~perr_sticky & ~mask;
        pend           = |(sticky_next & ~mask);
        rearm          = clr_valid & clr_cnt;
    end

    nvme_perr_prienc #(
        .width     (num_sources),
        .idx_width (src_width)
    ) u_prienc (
        .req     (perr_q),
        .idx     (enc_idx),
        .any_set (enc_any)
    );

    // Status registers. A re-arm coinciding with an error recaptures at once,
    // and the counter restarts at 1 rather than 0 in that case.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perr_sticky <= '0;
            first_valid <= 1'b0;
            first_src   <= '0;
            err_cnt     <= '0;
        end else begin
            perr_sticky <= sticky_next;

            if ((!first_valid || rearm) && enc_any) begin
                first_valid <= 1'b1;
                first_src   <= enc_idx;
            end else if (rearm) begin
                first_valid <= 1'b0;
            end

            if (rearm) begin
                err_cnt <= enc_any ? cnt_width'(1) : '0;
            end else if (enc_any && (err_cnt != {cnt_width{1'b1}})) begin
                err_cnt <= err_cnt + cnt_width'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // int_req is decoded from the state so that reset removes it without a clock.
    // HOLD waits for software to clear/mask everything, but a brand-new unmasked
    // error re-raises the request.
    always_comb begin
        state_next = state;
        int_req    = 1'b0;
        case (state)
            IDLE: begin
                if (pend) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                int_req = 1'b1;
                if (int_ack) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (|fresh_unmasked) begin
                    state_next = REPORT;
                end else if (!pend) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
